// File: rtl/audio_pkg.sv
// audio_pkg: shared state encoding, default sample width and volume helper for sound effects
package audio_pkg;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [2:0] {IDLE, ATTACK, SUSTAIN, RELEASE, GAP} state_t;
  function automatic int vol_max(input int vol_w);
    return 1 << vol_w;
  endfunction
endpackage

// File: rtl/vol_scaler.sv
// vol_scaler: registered (sample * volume) >> VOL_W with one clock of latency
module vol_scaler import audio_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int VOL_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_sig,
  input  logic [VOL_W:0]    i_vol,
  output logic [DATA_W-1:0] o_sig
);
  localparam int P_W = DATA_W + VOL_W + 1;
  logic [P_W-1:0] w_prod;
  assign w_prod = P_W'(i_sig) * P_W'(i_vol);
  always_ff @(posedge i_clk)
    o_sig <= !i_rst ? '0 : DATA_W'(w_prod >> VOL_W);
endmodule

// File: rtl/whistle_env.sv
// whistle_env: attack/sustain/release envelope gate repeated over BURSTS bursts with silent gaps
module whistle_env import audio_pkg::*; #(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int VOL_W         = 4,
  parameter int SUSTAIN_TICKS = 100,
  parameter int GAP_TICKS     = 300,
  parameter int BURSTS        = 1,
  parameter int CTR_W         = 10,
  parameter int RETRIG        = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tick,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_sig_in,
  output logic [DATA_W-1:0] o_sig_out,
  output logic [VOL_W:0]    o_vol,
  output logic              o_busy,
  output logic              o_done
);
  localparam int BW = $clog2(BURSTS + 1);
  localparam logic [VOL_W:0] V_MAX = (VOL_W + 1)'(vol_max(VOL_W));
  localparam logic [VOL_W:0] V_TOP = (VOL_W + 1)'(vol_max(VOL_W) - 1);
  localparam logic [VOL_W:0] V_ONE = (VOL_W + 1)'(1);
  localparam logic [CTR_W-1:0] S_END = CTR_W'(SUSTAIN_TICKS - 1);
  localparam logic [CTR_W-1:0] G_END = CTR_W'(GAP_TICKS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BURSTS - 1);
  state_t r_state, w_state;
  logic [VOL_W:0] r_vol, w_vol;
  logic [CTR_W-1:0] r_ctr, w_ctr;
  logic [BW-1:0] r_burst, w_burst;
  logic r_start_prev, r_abt, w_abt, r_done, w_done, w_edge;
  assign w_edge = i_start & ~r_start_prev;
  always_ff @(posedge i_clk)
    if (!i_rst) begin
      r_state      <= IDLE;
      r_vol        <= '0;
      r_ctr        <= '0;
      r_burst      <= '0;
      r_start_prev <= 1'b0;
      r_abt        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_vol        <= w_vol;
      r_ctr        <= w_ctr;
      r_burst      <= w_burst;
      r_start_prev <= i_start;
      r_abt        <= w_abt;
      r_done       <= w_done;
    end
  always_comb begin
    w_state = r_state;
    w_vol   = r_vol;
    w_ctr   = r_ctr;
    w_burst = r_burst;
    w_abt   = r_abt;
    w_done  = 1'b0;
    if (r_state == IDLE) begin
      w_vol = '0;
      if (w_edge) begin
        w_state = ATTACK;
        w_ctr   = '0;
        w_burst = '0;
        w_abt   = 1'b0;
      end
    end else if (i_abort) begin
      w_abt   = 1'b1;
      w_burst = B_LAST;
      if (r_state == GAP) begin
        w_state = IDLE;
        w_vol   = '0;
        w_ctr   = '0;
      end else if (r_state != RELEASE) begin
        w_state = RELEASE;
        w_ctr   = '0;
      end
    end else if (w_edge && RETRIG != 0) begin
      w_state = ATTACK;
      w_ctr   = '0;
      w_burst = '0;
      w_abt   = 1'b0;
    end else if (i_tick) begin
      case (r_state)
        ATTACK:
          if (r_vol >= V_TOP) begin
            w_vol   = V_MAX;
            w_state = SUSTAIN;
            w_ctr   = '0;
          end else w_vol = r_vol + V_ONE;
        SUSTAIN:
          if (r_ctr == S_END) begin
            w_state = RELEASE;
            w_ctr   = '0;
          end else w_ctr = r_ctr + CTR_W'(1);
        RELEASE:
          if (r_vol <= V_ONE) begin
            w_vol = '0;
            w_ctr = '0;
            if (r_burst == B_LAST) begin
              w_state = IDLE;
              w_done  = ~r_abt;
            end else begin
              w_burst = r_burst + BW'(1);
              w_state = GAP;
            end
          end else w_vol = r_vol - V_ONE;
        GAP:
          if (r_ctr == G_END) begin
            w_state = ATTACK;
            w_ctr   = '0;
          end else w_ctr = r_ctr + CTR_W'(1);
        default: w_state = r_state;
      endcase
    end
  end
  assign o_vol  = r_vol;
  assign o_busy = r_state != IDLE;
  assign o_done = r_done;
  vol_scaler #(.DATA_W(DATA_W), .VOL_W(VOL_W)) u_scaler (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_sig(i_sig_in),
    .i_vol(r_vol),
    .o_sig(o_sig_out)
  );
endmodule

// File: tb/tb_whistle_env.sv
// tb_whistle_env: scoreboard bench for whistle_env covering reset, bursts, abort, retrigger, tick stall and mid-gap reset
module tb_whistle_env;
  logic clk = 1'b0, rst = 1'b0, tick = 1'b0, start0 = 1'b0, start1 = 1'b0, abort = 1'b0;
  logic [7:0] sig_in = 8'd200;
  logic [7:0] so0, so1;
  logic [2:0] v0, v1;
  logic b0, b1, d0, d1;
  always #5 clk = ~clk;
  whistle_env #(.DATA_W(8), .VOL_W(2), .SUSTAIN_TICKS(3), .GAP_TICKS(2), .BURSTS(2), .CTR_W(10), .RETRIG(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_start(start0), .i_abort(abort), .i_sig_in(sig_in),
    .o_sig_out(so0), .o_vol(v0), .o_busy(b0), .o_done(d0)
  );
  whistle_env #(.DATA_W(8), .VOL_W(2), .SUSTAIN_TICKS(3), .GAP_TICKS(2), .BURSTS(2), .CTR_W(10), .RETRIG(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_start(start1), .i_abort(abort), .i_sig_in(sig_in),
    .o_sig_out(so1), .o_vol(v1), .o_busy(b1), .o_done(d1)
  );
  typedef struct {int vol; bit busy; bit done;} exp_t;
  exp_t q[$];
  localparam int BV[11] = '{1, 2, 3, 4, 4, 4, 4, 3, 2, 1, 0};
  int checks = 0, failures = 0, dc0 = 0, dc1 = 0, mark = 0;
  bit sel = 1'b0;
  string scn = "init";
  always @(negedge clk) begin
    if (d0 === 1'b1) dc0++;
    if (d1 === 1'b1) dc1++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s/%s observed=%0d expected=%0d", scn, tag, obs, exp);
    end
  endtask
  task automatic push(input int v, input bit b, input bit d);
    exp_t e;
    e.vol = v;
    e.busy = b;
    e.done = d;
    q.push_back(e);
  endtask
  task automatic push_burst(input bit last);
    for (int i = 0; i < 11; i++) push(BV[i], !(last && i == 10), last && i == 10);
    if (!last) begin
      push(0, 1, 0);
      push(0, 1, 0);
    end
  endtask
  task automatic run_ticks(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      check("sb_nonempty", q.size() > 0, 1);
      if (q.size() > 0) e = q.pop_front();
      check("vol", sel ? v1 : v0, e.vol);
      check("busy", sel ? b1 : b0, e.busy);
      check("done", sel ? d1 : d0, e.done);
      repeat (3) @(negedge clk);
      check("sig_out", sel ? so1 : so0, (sig_in * e.vol) >> 2);
    end
  endtask
  task automatic pulse(input bit which);
    if (which) start1 = 1'b1;
    else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    scn = "reset";
    start0 = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("sig_out", so0, 0);
    check("vol", v0, 0);
    check("busy", b0, 0);
    check("done", d0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("busy_after_release", b0, 1);
    start0 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("busy_rearm", b0, 0);
    rst = 1'b1;
    @(negedge clk);
    scn = "single";
    pulse(0);
    check("busy_on_edge", b0, 1);
    mark = dc0;
    push_burst(0);
    push_burst(1);
    run_ticks(24);
    check("done_count", dc0 - mark, 1);
    scn = "abort";
    pulse(0);
    mark = dc0;
    push(1, 1, 0); push(2, 1, 0); push(3, 1, 0); push(4, 1, 0); push(4, 1, 0);
    run_ticks(5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("vol_at_abort", v0, 4);
    check("busy_at_abort", b0, 1);
    check("sig_at_abort", so0, 200);
    push(3, 1, 0); push(2, 1, 0); push(1, 1, 0); push(0, 0, 0); push(0, 0, 0); push(0, 0, 0);
    run_ticks(6);
    check("done_count", dc0 - mark, 0);
    scn = "no_retrig";
    pulse(0);
    mark = dc0;
    push_burst(0);
    push_burst(1);
    run_ticks(2);
    pulse(0);
    run_ticks(22);
    check("done_count", dc0 - mark, 1);
    scn = "retrig";
    sel = 1'b1;
    mark = dc1;
    pulse(1);
    push_burst(0);
    for (int i = 0; i < 8; i++) push(BV[i], 1, 0);
    run_ticks(21);
    pulse(1);
    check("vol_kept", v1, 3);
    check("busy_kept", b1, 1);
    push(4, 1, 0); push(4, 1, 0); push(4, 1, 0); push(4, 1, 0);
    push(3, 1, 0); push(2, 1, 0); push(1, 1, 0); push(0, 1, 0);
    push(0, 1, 0); push(0, 1, 0);
    push_burst(1);
    run_ticks(21);
    check("done_count", dc1 - mark, 1);
    sel = 1'b0;
    scn = "freeze";
    pulse(0);
    mark = dc0;
    push_burst(0);
    push_burst(1);
    run_ticks(5);
    repeat (20) @(negedge clk);
    sig_in = 8'd80;
    @(negedge clk);
    check("sig_track", so0, 80);
    repeat (29) @(negedge clk);
    check("vol_frozen", v0, 4);
    check("busy_frozen", b0, 1);
    sig_in = 8'd200;
    @(negedge clk);
    check("sig_restore", so0, 200);
    run_ticks(19);
    check("done_count", dc0 - mark, 1);
    scn = "rst_gap";
    pulse(0);
    mark = dc0;
    push_burst(0);
    push_burst(1);
    run_ticks(12);
    q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("sig_out", so0, 0);
    check("vol", v0, 0);
    check("busy", b0, 0);
    check("done", d0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("done_count_rst", dc0 - mark, 0);
    pulse(0);
    mark = dc0;
    push_burst(0);
    push_burst(1);
    run_ticks(24);
    check("done_count", dc0 - mark, 1);
    scn = "end";
    check("sb_left", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
